// File: rtl/uart_denetleyici.sv
// Wishbone-slave 8N1 UART: CTRL/STATUS register file, byte FIFOs on both directions,
// programmable baud divisor shared by transmitter and receiver.

module uart_denetleyici_fifo #(
  parameter int DERINLIK = 32
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] wdata,
  output logic [7:0] rdata,
  output logic       full,
  output logic       empty
);
  localparam int AW = $clog2(DERINLIK);

  logic [7:0]  mem_r [DERINLIK];
  logic [AW:0] wr_ptr_r;
  logic [AW:0] rd_ptr_r;
  logic        push_ok_s;
  logic        pop_ok_s;

  assign empty     = (wr_ptr_r == rd_ptr_r);
  assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
  assign pop_ok_s  = pop & ~empty;
  // a pop in the same cycle frees the slot, so a full FIFO may still take the push
  assign push_ok_s = push & (~full | pop_ok_s);
  assign rdata     = mem_r[rd_ptr_r[AW-1:0]];

  // read/write pointers, one wrap bit above the index
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= {(AW+1){1'b0}};
      rd_ptr_r <= {(AW+1){1'b0}};
    end else begin
      if (push_ok_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
      if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
    end
  end

  // byte storage
  always_ff @(posedge clk_i) begin
    if (push_ok_s) mem_r[wr_ptr_r[AW-1:0]] <= wdata;
  end
endmodule

module uart_denetleyici #(
  parameter int FIFO_DERINLIK = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [7:0]  adr_i,
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        uart_tx_o,
  input  logic        uart_rx_i
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} seri_durum_e;

  logic        ack_r, req_we_r;
  logic [1:0]  req_adr_r;
  logic [15:0] req_hi_r;
  logic [7:0]  req_lo_r;
  logic [2:0]  req_sel_r;
  logic        tx_en_r, rx_en_r;
  logic [15:0] baud_div_r;
  logic        req_s, wr_commit_s;
  logic        tx_push_s, tx_pop_s, tx_full_s, tx_empty_s;
  logic        rx_push_s, rx_pop_s, rx_full_s, rx_empty_s;
  logic [7:0]  tx_head_s, rx_head_s;
  logic [31:0] rdata_s;
  seri_durum_e tx_state_r, rx_state_r;
  logic [15:0] tx_cnt_r, tx_div_r, rx_cnt_r, rx_div_r;
  logic [2:0]  tx_bit_r, rx_bit_r;
  logic [7:0]  tx_shift_r, rx_shift_r;
  logic        tx_line_r, rx_meta_r, rx_sync_r, rx_prev_r;
  logic        unused_s;

  assign unused_s    = ^{adr_i[7:4], adr_i[1:0], dat_i[15:8], sel_i[1]};
  assign req_s       = cyc_i & stb_i & ~ack_r;
  assign wr_commit_s = ack_r & req_we_r;
  assign tx_push_s   = wr_commit_s && (req_adr_r == 2'b11) && req_sel_r[0];
  assign rx_pop_s    = ack_r && !req_we_r && (req_adr_r == 2'b10);
  assign tx_pop_s    = (tx_state_r == S_IDLE) && tx_en_r && !tx_empty_s && (baud_div_r >= 16'd2);
  assign rx_push_s   = (rx_state_r == S_STOP) && (rx_cnt_r == rx_div_r - 16'd1) && rx_sync_r;
  assign ack_o       = ack_r;
  assign dat_o       = rdata_s;
  assign uart_tx_o   = tx_line_r;

  uart_denetleyici_fifo #(.DERINLIK(FIFO_DERINLIK)) u_tx_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .push(tx_push_s), .pop(tx_pop_s),
    .wdata(req_lo_r), .rdata(tx_head_s), .full(tx_full_s), .empty(tx_empty_s)
  );

  uart_denetleyici_fifo #(.DERINLIK(FIFO_DERINLIK)) u_rx_fifo (
    .clk_i(clk_i), .rst_ni(rst_ni), .push(rx_push_s), .pop(rx_pop_s),
    .wdata(rx_shift_r), .rdata(rx_head_s), .full(rx_full_s), .empty(rx_empty_s)
  );

  // request capture: the transaction commits even if the master drops cyc during ack
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_r     <= 1'b0;
      req_we_r  <= 1'b0;
      req_adr_r <= 2'b00;
      req_hi_r  <= 16'd0;
      req_lo_r  <= 8'd0;
      req_sel_r <= 3'b000;
    end else begin
      ack_r <= req_s;
      if (req_s) begin
        req_we_r  <= we_i;
        req_adr_r <= adr_i[3:2];
        req_hi_r  <= dat_i[31:16];
        req_lo_r  <= dat_i[7:0];
        req_sel_r <= {sel_i[3], sel_i[2], sel_i[0]};
      end
    end
  end

  // CTRL register with per-byte lane enables
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_en_r    <= 1'b0;
      rx_en_r    <= 1'b0;
      baud_div_r <= 16'd0;
    end else if (wr_commit_s && (req_adr_r == 2'b00)) begin
      if (req_sel_r[0]) {rx_en_r, tx_en_r} <= req_lo_r[1:0];
      if (req_sel_r[1]) baud_div_r[7:0]    <= req_hi_r[7:0];
      if (req_sel_r[2]) baud_div_r[15:8]   <= req_hi_r[15:8];
    end
  end

  // read data is live during the ack cycle only
  always_comb begin
    rdata_s = 32'd0;
    if (ack_r) begin
      case (req_adr_r)
        2'b00:   rdata_s = {baud_div_r, 14'd0, rx_en_r, tx_en_r};
        2'b01:   rdata_s = {28'd0, rx_empty_s, rx_full_s, tx_empty_s, tx_full_s};
        2'b10:   rdata_s = rx_empty_s ? 32'd0 : {24'd0, rx_head_s};
        default: rdata_s = 32'd0;
      endcase
    end else begin
      rdata_s = 32'd0;
    end
  end

  // transmitter: divisor latched per frame, line registered
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tx_state_r <= S_IDLE;
      tx_cnt_r   <= 16'd0;
      tx_div_r   <= 16'd0;
      tx_bit_r   <= 3'd0;
      tx_shift_r <= 8'd0;
      tx_line_r  <= 1'b1;
    end else begin
      case (tx_state_r)
        S_IDLE: begin
          tx_line_r <= 1'b1;
          if (tx_pop_s) begin
            tx_state_r <= S_START;
            tx_div_r   <= baud_div_r;
            tx_shift_r <= tx_head_s;
            tx_cnt_r   <= 16'd0;
            tx_bit_r   <= 3'd0;
            tx_line_r  <= 1'b0;
          end
        end
        S_START: begin
          if (tx_cnt_r == tx_div_r - 16'd1) begin
            tx_cnt_r   <= 16'd0;
            tx_state_r <= S_DATA;
            tx_line_r  <= tx_shift_r[0];
          end else begin
            tx_cnt_r <= tx_cnt_r + 16'd1;
          end
        end
        S_DATA: begin
          if (tx_cnt_r == tx_div_r - 16'd1) begin
            tx_cnt_r <= 16'd0;
            if (tx_bit_r == 3'd7) begin
              tx_state_r <= S_STOP;
              tx_line_r  <= 1'b1;
            end else begin
              tx_bit_r   <= tx_bit_r + 3'd1;
              tx_shift_r <= {1'b0, tx_shift_r[7:1]};
              tx_line_r  <= tx_shift_r[1];
            end
          end else begin
            tx_cnt_r <= tx_cnt_r + 16'd1;
          end
        end
        S_STOP: begin
          if (tx_cnt_r == tx_div_r - 16'd1) begin
            tx_cnt_r   <= 16'd0;
            tx_state_r <= S_IDLE;
          end else begin
            tx_cnt_r <= tx_cnt_r + 16'd1;
          end
        end
        default: begin
          tx_state_r <= S_IDLE;
          tx_line_r  <= 1'b1;
        end
      endcase
    end
  end

  // two-flop synchronizer plus previous value for falling-edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
      rx_prev_r <= 1'b1;
    end else begin
      rx_meta_r <= uart_rx_i;
      rx_sync_r <= rx_meta_r;
      rx_prev_r <= rx_sync_r;
    end
  end

  // receiver: counter starts at 1 so the start check lands mid-bit despite sync delay
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rx_state_r <= S_IDLE;
      rx_cnt_r   <= 16'd0;
      rx_div_r   <= 16'd0;
      rx_bit_r   <= 3'd0;
      rx_shift_r <= 8'd0;
    end else begin
      case (rx_state_r)
        S_IDLE: begin
          if (rx_en_r && (baud_div_r >= 16'd2) && rx_prev_r && !rx_sync_r) begin
            rx_state_r <= S_START;
            rx_div_r   <= baud_div_r;
            rx_cnt_r   <= 16'd1;
          end
        end
        S_START: begin
          if (rx_cnt_r >= {1'b0, rx_div_r[15:1]}) begin
            rx_cnt_r <= 16'd0;
            rx_bit_r <= 3'd0;
            rx_state_r <= rx_sync_r ? S_IDLE : S_DATA;
          end else begin
            rx_cnt_r <= rx_cnt_r + 16'd1;
          end
        end
        S_DATA: begin
          if (rx_cnt_r == rx_div_r - 16'd1) begin
            rx_cnt_r   <= 16'd0;
            rx_shift_r <= {rx_sync_r, rx_shift_r[7:1]};
            if (rx_bit_r == 3'd7) rx_state_r <= S_STOP;
            else rx_bit_r <= rx_bit_r + 3'd1;
          end else begin
            rx_cnt_r <= rx_cnt_r + 16'd1;
          end
        end
        S_STOP: begin
          if (rx_cnt_r == rx_div_r - 16'd1) begin
            rx_cnt_r   <= 16'd0;
            rx_state_r <= S_IDLE;
          end else begin
            rx_cnt_r <= rx_cnt_r + 16'd1;
          end
        end
        default: rx_state_r <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_denetleyici.sv
// Self-checking bench for uart_denetleyici: bus tasks, serial line driver/monitor and
// queue-based FIFO reference model.

module tb_uart_denetleyici;
  localparam logic [7:0] A_CTRL = 8'h00, A_STAT = 8'h04, A_RDAT = 8'h08, A_WDAT = 8'h0C;
  localparam int DEPTH = 32;

  logic        clk_i = 1'b0, rst_ni = 1'b0;
  logic        cyc_i = 1'b0, stb_i = 1'b0, we_i = 1'b0;
  logic [7:0]  adr_i = 8'd0;
  logic [31:0] dat_i = 32'd0;
  logic [3:0]  sel_i = 4'd0;
  logic        uart_rx_i = 1'b1;
  logic [31:0] dat_o;
  logic        ack_o, uart_tx_o;

  int checks = 0, errors = 0;
  logic [7:0] tx_q[$];
  logic [7:0] rx_q[$];

  always #5 clk_i = ~clk_i;

  uart_denetleyici dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .adr_i(adr_i), .dat_i(dat_i), .sel_i(sel_i), .dat_o(dat_o), .ack_o(ack_o),
    .uart_tx_o(uart_tx_o), .uart_rx_i(uart_rx_i)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] status_exp();
    return {28'd0, rx_q.size() == 0, rx_q.size() == DEPTH, tx_q.size() == 0, tx_q.size() == DEPTH};
  endfunction

  function automatic logic [31:0] rdata_exp();
    if (rx_q.size() == 0) return 32'd0;
    return {24'd0, rx_q.pop_front()};
  endfunction

  // caller is aligned 1 time unit after a rising edge; returns aligned the same way
  task automatic wb_xfer(input bit we, input logic [7:0] adr, input logic [31:0] wd,
                         input logic [3:0] sel, input bit hold,
                         output logic [31:0] rd, output bit one_ack);
    bit seen;
    seen = 1'b0;
    rd = 32'd0;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = wd; sel_i = sel;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk_i); #1;
      if (ack_o) begin
        seen = 1'b1;
        break;
      end
    end
    check_value("ack_seen", {31'd0, seen}, 32'd1);
    rd = dat_o;
    if (!hold) begin
      cyc_i = 1'b0; stb_i = 1'b0; adr_i = A_STAT; dat_i = 32'd0;
    end
    @(posedge clk_i); #1;
    one_ack = (ack_o == 1'b0);
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; sel_i = 4'd0;
  endtask

  task automatic wb_write(input logic [7:0] adr, input logic [31:0] wd, input logic [3:0] sel);
    logic [31:0] d;
    bit o;
    wb_xfer(1'b1, adr, wd, sel, 1'b1, d, o);
  endtask

  task automatic wb_read(input logic [7:0] adr, output logic [31:0] rd);
    bit o;
    wb_xfer(1'b0, adr, 32'd0, 4'hF, 1'b1, rd, o);
  endtask

  task automatic tx_push(input logic [7:0] b, input logic [3:0] sel);
    wb_write(A_WDAT, {24'd0, b}, sel);
    if (sel[0] && tx_q.size() < DEPTH) tx_q.push_back(b);
  endtask

  task automatic wait_tx_low(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (uart_tx_o == 1'b0) begin
        found = 1'b1;
        break;
      end
      @(posedge clk_i); #1;
    end
  endtask

  // frame shape: start 0, eight constant-width data bits, stop 1, then an idle-high cycle
  task automatic tx_check_frame(input int div);
    bit found;
    int bad, bi;
    logic [7:0] got, exp;
    wait_tx_low(20 * div + 20, found);
    check_value("tx_start_seen", {31'd0, found}, 32'd1);
    bad = 0;
    got = 8'd0;
    for (int c = 0; c < 10 * div; c++) begin
      bi = c / div;
      if (bi == 0) begin
        if (uart_tx_o !== 1'b0) bad++;
      end else if (bi == 9) begin
        if (uart_tx_o !== 1'b1) bad++;
      end else if (c % div == 0) begin
        got[bi-1] = uart_tx_o;
      end else if (uart_tx_o !== got[bi-1]) begin
        bad++;
      end
      @(posedge clk_i); #1;
    end
    if (uart_tx_o !== 1'b1) bad++;
    exp = 8'd0;
    if (tx_q.size() > 0) exp = tx_q.pop_front();
    check_value("tx_byte", {24'd0, got}, {24'd0, exp});
    check_value("tx_bit_timing", bad, 32'd0);
  endtask

  task automatic rx_frame(input logic [7:0] b, input bit stop, input int div);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx_i = bits[i];
      repeat (div) @(posedge clk_i);
      #1;
    end
    uart_rx_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    if (stop && rx_q.size() < DEPTH) rx_q.push_back(b);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic [31:0] d, d1;
    logic [7:0]  b, a;
    bit one, found;
    int div, n, lows;

    repeat (3) @(posedge clk_i);
    #1;
    check_value("rst_ack", {31'd0, ack_o}, 32'd0);
    check_value("rst_dat", dat_o, 32'd0);
    check_value("rst_tx", {31'd0, uart_tx_o}, 32'd1);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
    wb_read(A_STAT, d); check_value("status_rst", d, 32'h0000_000A);
    wb_read(A_CTRL, d); check_value("ctrl_rst", d, 32'd0);

    wb_xfer(1'b1, A_CTRL, 32'h0010_0003, 4'hF, 1'b1, d, one);
    check_value("ack_one_cycle", {31'd0, one}, 32'd1);
    wb_read(A_CTRL, d); check_value("ctrl_full_write", d, 32'h0010_0003);
    wb_write(A_CTRL, 32'hFFFF_0000, 4'h4);
    wb_read(A_CTRL, d); check_value("ctrl_lane_write", d, 32'h00FF_0003);

    wb_write(A_CTRL, 32'h0010_0001, 4'hF);
    tx_push(8'hA5, 4'h1);
    tx_check_frame(16);
    wb_read(A_STAT, d); check_value("tx_done_status", d, status_exp());

    for (int f = 0; f < 3; f++) begin
      div = $urandom_range(2, 12);
      wb_write(A_CTRL, {div[15:0], 16'd0}, 4'hF);
      n = $urandom_range(1, 3);
      for (int i = 0; i < n; i++) tx_push(8'($urandom), 4'h1);
      tx_push(8'($urandom), 4'hE);
      wb_write(A_CTRL, {div[15:0], 16'd1}, 4'hF);
      for (int i = 0; i < n; i++) tx_check_frame(div);
      wb_read(A_STAT, d); check_value("tx_rand_status", d, status_exp());
    end

    wb_write(A_CTRL, 32'h0001_0001, 4'hF);
    tx_push(8'h5A, 4'h1);
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_i); #1;
      if (!uart_tx_o) lows++;
    end
    check_value("div1_no_tx", lows, 32'd0);
    wb_read(A_STAT, d); check_value("div1_held", d, status_exp());
    wb_write(A_CTRL, 32'h0008_0001, 4'hF);
    tx_check_frame(8);

    wb_write(A_CTRL, 32'h0004_0000, 4'hF);
    for (int i = 0; i < DEPTH; i++) tx_push(8'($urandom), 4'h1);
    wb_read(A_STAT, d); check_value("tx_full", d, status_exp());
    tx_push(8'hEE, 4'h1);
    wb_write(A_CTRL, 32'h0004_0001, 4'h1);
    for (int i = 0; i < DEPTH; i++) tx_check_frame(4);
    wait_tx_low(80, found);
    check_value("tx_33rd_dropped", {31'd0, found}, 32'd0);
    wb_read(A_STAT, d); check_value("tx_drained", d, status_exp());

    wb_write(A_CTRL, 32'h0010_0001, 4'hF);
    tx_push(8'h81, 4'h1);
    wait_tx_low(100, found);
    check_value("mid_frame_start", {31'd0, found}, 32'd1);
    #3 rst_ni = 1'b0;
    #1 check_value("rst_async_tx", {31'd0, uart_tx_o}, 32'd1);
    tx_q.delete();
    rx_q.delete();
    #13 rst_ni = 1'b1;
    @(posedge clk_i); #1;
    wb_read(A_STAT, d); check_value("status_after_rst", d, 32'h0000_000A);
    wb_read(A_CTRL, d); check_value("ctrl_after_rst", d, 32'd0);

    wb_write(A_CTRL, 32'h0010_0002, 4'hF);
    rx_frame(8'h3C, 1'b1, 16);
    wb_read(A_RDAT, d); check_value("rx_3c", d, rdata_exp());
    wb_read(A_STAT, d); check_value("rx_empty_after", d, status_exp());
    rx_frame(8'($urandom), 1'b0, 16);
    wb_read(A_STAT, d); check_value("rx_bad_stop", d, status_exp());
    uart_rx_i = 1'b0;
    repeat (4) @(posedge clk_i);
    #1 uart_rx_i = 1'b1;
    repeat (200) @(posedge clk_i);
    #1;
    wb_read(A_STAT, d); check_value("rx_glitch", d, status_exp());
    wb_read(A_RDAT, d); check_value("rx_empty_read", d, 32'd0);

    for (int i = 0; i < 4; i++) begin
      div = $urandom_range(4, 12);
      wb_write(A_CTRL, {div[15:0], 16'd2}, 4'hF);
      rx_frame(8'($urandom), 1'b1, div);
      wb_read(A_RDAT, d); check_value("rx_rand", d, rdata_exp());
    end

    wb_write(A_CTRL, 32'h0004_0002, 4'hF);
    for (int i = 0; i < DEPTH + 1; i++) rx_frame(8'($urandom), 1'b1, 4);
    wb_read(A_STAT, d); check_value("rx_full", d, status_exp());
    for (int i = 0; i < DEPTH; i++) begin
      wb_read(A_RDAT, d); check_value("rx_order", d, rdata_exp());
    end
    wb_read(A_RDAT, d); check_value("rx_33rd_lost", d, 32'd0);

    for (int k = 36; k <= 42; k++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      rx_frame(a, 1'b1, 4);
      fork
        rx_frame(b, 1'b1, 4);
        begin
          repeat (k) @(posedge clk_i);
          #1 wb_read(A_RDAT, d1);
        end
      join
      check_value("sim_first", d1, rdata_exp());
      wb_read(A_RDAT, d); check_value("sim_second", d, rdata_exp());
      wb_read(A_STAT, d); check_value("sim_status", d, status_exp());
    end

    wb_xfer(1'b1, A_CTRL, 32'h0020_0001, 4'hF, 1'b0, d, one);
    wb_read(A_CTRL, d); check_value("cyc_drop_commit", d, 32'h0020_0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/uart_denetleyici.md
# uart_denetleyici

Wishbone-slave UART that sits directly downstream of the core's Wishbone master, answering cycles for the 0x2000_0000 (UART) window. It holds a control/status register file, 32-entry TX and RX byte FIFOs, and an 8N1 serial transmitter/receiver with a programmable baud divisor. It generates exactly one single-cycle `ack_o` per master request, which the master uses to leave its bus state.

## Interface

**Parameters**
- `FIFO_DERINLIK`, default 32: entries per FIFO; power of two, ≥2.

**Ports** (clock and reset first)
- `clk_i` input 1: single clock for all logic.
- `rst_ni` input 1: reset, asynchronous and active-low.
- `cyc_i` input 1: Wishbone cycle; this slave's select from the master.
- `stb_i` input 1: strobe.
- `we_i` input 1: write enable.
- `adr_i` input 8: byte address; only `[3:2]` is decoded.
- `dat_i` input 32: write data.
- `sel_i` input 4: byte lanes for writes.
- `dat_o` output 32: read data, valid only while `ack_o`=1.
- `ack_o` output 1: one-cycle acknowledge.
- `uart_tx_o` output 1: serial out, idle high.
- `uart_rx_i` input 1: serial in, asynchronous to `clk_i`.

## Operation

**Register map** (`adr_i[3:2]`)
- `00` CTRL (R/W):
  - `[0]` `tx_en`, `[1]` `rx_en`, `[31:16]` `baud_div`; other bits read 0.
  - Writes honor `sel_i` per byte.
- `01` STATUS (RO):
  - `[0]` tx_full, `[1]` tx_empty, `[2]` rx_full, `[3]` rx_empty.
  - Writes are ignored but still acked.
- `10` RDATA (RO): read returns `{24'b0, rx_head}` and pops the RX FIFO.
  - If RX is empty: returns 0, no pop.
- `11` WDATA (WO): write with `sel_i[0]`=1 pushes `dat_i[7:0]` into the TX FIFO.
  - If TX is full: byte dropped, still acked.
  - Reads return 0.

**Bus handshake**
- A request is `cyc_i & stb_i & ~ack_o`.
- It registers `ack_o`=1 for the next cycle only.
- Register write, FIFO push and FIFO pop occur at the clock edge that ends the ack cycle.
- `dat_o` is driven from the current register/FIFO state during the ack cycle. It is 0 otherwise.

**Transmitter** (states IDLE, START, DATA, STOP)
- IDLE → START when `tx_en`=1, TX FIFO non-empty and `baud_div`≥2.
  - On that transition: pop one byte and latch `baud_div` for the whole frame.
- Each bit lasts `baud_div` cycles:
  - START drives 0.
  - DATA drives 8 bits LSB first (3-bit counter).
  - STOP drives 1, then returns to IDLE.
- Clearing `tx_en` mid-frame finishes the current frame, then holds IDLE.

**Receiver** (states IDLE, START, DATA, STOP)
- `uart_rx_i` passes through a 2-FF synchronizer.
- IDLE → START on a synchronized 1→0 edge while `rx_en`=1 and `baud_div`≥2. Latch `baud_div` at this point.
- START check at `baud_div/2` (floor): if the line is 1, treat as a glitch and return to IDLE.
- Sample 8 data bits at `baud_div` intervals after that, then the stop bit.
- Stop bit = 1: push the byte, unless RX is full, in which case drop the byte.
- Stop bit = 0: discard the frame.
- Return to IDLE after the stop sample.

**FIFOs**
- Pointers are `log2(FIFO_DERINLIK)+1` bits and wrap modulo 2·depth.
- Full/empty come from MSB/index comparison.
- Simultaneous push and pop on one FIFO is legal:
  - Count unchanged.
  - When empty, only the push takes effect.

## Timing

**Reset values**
- `ack_o`=0, `dat_o`=0, `uart_tx_o`=1.
- CTRL=0; both FIFOs empty; both serial FSMs in IDLE.

**Latencies**
- Bus: request seen at edge n → `ack_o` high in cycle n+1 → low in n+2.
  - Back-to-back requests therefore complete at most every 2 cycles.
- TX: start bit begins on the cycle after the IDLE→START pop.
  - Frame length is exactly 10·`baud_div` cycles.
- RX: byte appears in the FIFO (rx_empty=0) one cycle after the stop-bit sample.

**Boundary behaviour**
- `baud_div` < 2: both FSMs stay in IDLE. A frame in flight completes using its latched divisor.
- `rst_ni` low mid-frame: immediate asynchronous return to reset values. `uart_tx_o` goes high without waiting for a clock.
- `cyc_i` dropped during the ack cycle: the transaction still commits.

## Test plan

- **Reset:** `rst_ni`=0 asynchronously mid-TX frame → `uart_tx_o`=1 immediately; STATUS read after release = 0x0000_000A.
- **Handshake:** write CTRL=0x0010_0003 with `sel_i`=0xF, `stb_i` held 2 cycles → `ack_o` high exactly one cycle; CTRL readback 0x0010_0003. Then write 0xFFFF_0000 with `sel_i`=0x4 → readback 0x00FF_0003.
- **TX frame:** `baud_div`=16, `tx_en`=1, write WDATA=0xA5 → `uart_tx_o` sequence 0,1,0,1,0,0,1,0,1,1, each bit exactly 16 cycles; then tx_empty=1.
- **RX loopback plus errors:** drive a 0x3C frame at `baud_div`=16 → RDATA=0x3C, then rx_empty=1. A frame with stop=0 is not stored. A 4-cycle low glitch is ignored. Reading RDATA while empty returns 0.
- **Full/overflow:**
  - Push 33 bytes with `tx_en`=0 → tx_full=1 after 32; the 33rd is dropped.
  - Receive 33 frames → rx_full=1; first 32 bytes are read back in order; the 33rd is lost.
- **Simultaneous events:** RDATA pop in the same cycle an RX byte is pushed with 1 entry held → count stays 1 and the new byte is read next.
